board_port_arbiter: RTL and testbench

Arbiter that shares the single-port board cell memory between three requesters: the video renderer (`vid`), the active-piece engine (`ap`, collision probes and piece lock-in writes) and the line-clear engine (`lc`, row scans and row shifts). It sits between the game FSM, the line-clear engine and the board memory. It issues one memory access per cycle and returns read data with a per-requester valid strobe. It also lets the line-clear engine hold the board atomically against the active-piece engine while it shifts rows.

---
 rtl/board_port_arbiter_if.sv | 39 +++
 rtl/board_port_arbiter.sv | 125 ++++++++++++
 tb/tb_board_port_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/board_port_arbiter_if.sv
// Request/grant/read-return bundle between the board requesters and the arbiter,
// plus the single-port board memory bus the arbiter drives.
interface board_port_arbiter_if #(
   parameter int CW = 3
);
   logic          vid_req, ap_req, lc_req;
   logic          ap_we, lc_we;
   logic [3:0]    vid_x, ap_x, lc_x;
   logic [4:0]    vid_y, ap_y, lc_y;
   logic [CW-1:0] ap_wdata, lc_wdata;
   logic          lc_lock;
   logic          vid_gnt, ap_gnt, lc_gnt;
   logic          vid_rvalid, ap_rvalid, lc_rvalid;
   logic [CW-1:0] rdata;
   logic          mem_en, mem_we;
   logic [7:0]    mem_addr;
   logic [CW-1:0] mem_wdata;
   logic [CW-1:0] mem_rdata;

   modport master (
      output vid_req, ap_req, lc_req, ap_we, lc_we,
      output vid_x, ap_x, lc_x, vid_y, ap_y, lc_y,
      output ap_wdata, lc_wdata, lc_lock,
      input  vid_gnt, ap_gnt, lc_gnt,
      input  vid_rvalid, ap_rvalid, lc_rvalid, rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  vid_req, ap_req, lc_req, ap_we, lc_we,
      input  vid_x, ap_x, lc_x, vid_y, ap_y, lc_y,
      input  ap_wdata, lc_wdata, lc_lock,
      output vid_gnt, ap_gnt, lc_gnt,
      output vid_rvalid, ap_rvalid, lc_rvalid, rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );
endinterface

// File: rtl/board_port_arbiter.sv
// Shares the single-port board memory between video, active-piece and line-clear
// requesters: fixed video priority, ap/lc round-robin, and an lc-held lock against ap.
module board_port_arbiter #(
   parameter int W  = 10,
   parameter int H  = 20,
   parameter int CW = 3
) (
   input  logic               clk,
   input  logic               rst,
   board_port_arbiter_if.slave bus
);
   localparam int NR  = 3;
   localparam int VID = 0;
   localparam int AP  = 1;
   localparam int LC  = 2;

   logic [NR-1:0] req, we, oob, gnt;
   logic [3:0]    x     [NR];
   logic [4:0]    y     [NR];
   logic [CW-1:0] wdata [NR];
   logic [7:0]    addr  [NR];

   logic          rr_ptr_q, rr_ptr_d;
   logic          lock_owner_q, lock_owner_d;
   logic [NR-1:0] rd_sel_q, rd_sel_d;
   logic          rd_oob_q, rd_oob_d;
   logic          lock_live;

   logic          win_any, win_we, win_oob;
   logic [7:0]    win_addr;
   logic [CW-1:0] win_wdata;

   assign req      = {bus.lc_req, bus.ap_req, bus.vid_req};
   assign we       = {bus.lc_we, bus.ap_we, 1'b0};
   assign x[VID]   = bus.vid_x;
   assign x[AP]    = bus.ap_x;
   assign x[LC]    = bus.lc_x;
   assign y[VID]   = bus.vid_y;
   assign y[AP]    = bus.ap_y;
   assign y[LC]    = bus.lc_y;
   assign wdata[VID] = '0;
   assign wdata[AP]  = bus.ap_wdata;
   assign wdata[LC]  = bus.lc_wdata;

   generate
      for (genvar gi = 0; gi < NR; gi++) begin : g_req
         assign oob[gi]  = (32'(x[gi]) >= W) || (32'(y[gi]) >= H);
         assign addr[gi] = 8'(32'(y[gi]) * W + 32'(x[gi]));
      end
   endgenerate

   // Dropping lc_lock releases the lock in the same cycle, so ap may compete at once.
   assign lock_live = lock_owner_q & bus.lc_lock;

   always_comb begin
      gnt = '0;
      if (!rst) begin
         if (req[VID]) begin
            gnt[VID] = 1'b1;
         end else if (lock_live) begin
            gnt[LC] = req[LC];
         end else if (req[AP] && req[LC]) begin
            if (rr_ptr_q) gnt[LC] = 1'b1;
            else          gnt[AP] = 1'b1;
         end else begin
            gnt[AP] = req[AP];
            gnt[LC] = req[LC];
         end
      end
   end

   always_comb begin
      win_any   = 1'b0;
      win_we    = 1'b0;
      win_oob   = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      for (int i = 0; i < NR; i++) begin
         if (gnt[i]) begin
            win_any   = 1'b1;
            win_we    = we[i];
            win_oob   = oob[i];
            win_addr  = addr[i];
            win_wdata = wdata[i];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt[AP])      rr_ptr_d = 1'b1;
      else if (gnt[LC]) rr_ptr_d = 1'b0;
      lock_owner_d = bus.lc_lock & (lock_owner_q | gnt[LC]);
      rd_sel_d     = gnt & ~we;
      rd_oob_d     = win_oob;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q     <= 1'b0;
         lock_owner_q <= 1'b0;
         rd_sel_q     <= '0;
         rd_oob_q     <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         lock_owner_q <= lock_owner_d;
         rd_sel_q     <= rd_sel_d;
         rd_oob_q     <= rd_oob_d;
      end
   end

   assign bus.vid_gnt   = gnt[VID];
   assign bus.ap_gnt    = gnt[AP];
   assign bus.lc_gnt    = gnt[LC];
   assign bus.mem_en    = win_any & ~win_oob;
   assign bus.mem_we    = win_we;
   assign bus.mem_addr  = win_addr;
   assign bus.mem_wdata = win_wdata;

   // Reset masks an in-flight response in the cycle it is asserted.
   assign bus.vid_rvalid = rd_sel_q[VID] & ~rst;
   assign bus.ap_rvalid  = rd_sel_q[AP]  & ~rst;
   assign bus.lc_rvalid  = rd_sel_q[LC]  & ~rst;
   assign bus.rdata      = ((|rd_sel_q) && !rst) ? (rd_oob_q ? '1 : bus.mem_rdata) : '0;
endmodule

// File: tb/tb_board_port_arbiter.sv
// Randomised scoreboard bench for board_port_arbiter: a rule-level model predicts grants
// and read data; a separate monitor matches read responses against queued expectations.
module tb_board_port_arbiter;
   localparam int W  = 10;
   localparam int H  = 20;
   localparam int CW = 3;

   typedef struct {
      int who;
      int data;
      int cyc;
   } exp_t;

   typedef struct {
      bit req;
      bit we;
      int x;
      int y;
      int wd;
   } rq_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   board_port_arbiter_if #(.CW(CW)) bus();
   board_port_arbiter #(.W(W), .H(H), .CW(CW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   logic [CW-1:0] mem [256];
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata     <= bus.mem_wdata;
         end else begin
            bus.mem_rdata <= mem[bus.mem_addr];
         end
      end
   end

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   exp_t expq[$];
   rq_t  r[3];
   bit   lock_v;
   int   board_m[256];
   int   rr_m;
   bit   lock_m;
   int   last_win;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endfunction

   // Reference model: evaluates the arbitration rules for the inputs of this cycle.
   task automatic check_cycle(input bit do_rst);
      int  win;
      bit  oob;
      int  a;
      win = -1;
      if (!do_rst) begin
         if (r[0].req) win = 0;
         else if (lock_m && lock_v) win = r[2].req ? 2 : -1;
         else if (r[1].req && r[2].req) win = (rr_m == 1) ? 2 : 1;
         else if (r[1].req) win = 1;
         else if (r[2].req) win = 2;
      end
      last_win = win;
      chk("grant", {29'd0, bus.lc_gnt, bus.ap_gnt, bus.vid_gnt}, (win < 0) ? 0 : (1 << win));
      if (win < 0) begin
         chk("idle_bus", {19'd0, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
      end else begin
         oob = (r[win].x >= W) || (r[win].y >= H);
         a   = r[win].y * W + r[win].x;
         chk("mem_en", {31'd0, bus.mem_en}, {31'd0, !oob});
         chk("mem_we", {31'd0, bus.mem_we}, {31'd0, r[win].we});
         if (!oob) chk("mem_addr", {24'd0, bus.mem_addr}, a);
         if (!oob && r[win].we) chk("mem_wdata", {29'd0, bus.mem_wdata}, r[win].wd);
         if (r[win].we) begin
            if (!oob) board_m[a] = r[win].wd;
         end else begin
            expq.push_back('{who: win, data: oob ? 7 : board_m[a], cyc: cyc});
         end
         if (win == 1) rr_m = 1;
         else if (win == 2) rr_m = 0;
      end
      lock_m = !do_rst && lock_v && (lock_m || win == 2);
      if (do_rst) begin
         rr_m = 0;
         chk("rst_outputs", {26'd0, bus.vid_rvalid, bus.ap_rvalid, bus.lc_rvalid, bus.rdata}, 0);
      end
   endtask

   task automatic step(input bit do_rst);
      @(negedge clk);
      cyc++;
      rst = do_rst;
      if (do_rst) expq.delete();
      bus.vid_req  = r[0].req;
      bus.vid_x    = 4'(r[0].x);
      bus.vid_y    = 5'(r[0].y);
      bus.ap_req   = r[1].req;
      bus.ap_we    = r[1].we;
      bus.ap_x     = 4'(r[1].x);
      bus.ap_y     = 5'(r[1].y);
      bus.ap_wdata = CW'(r[1].wd);
      bus.lc_req   = r[2].req;
      bus.lc_we    = r[2].we;
      bus.lc_x     = 4'(r[2].x);
      bus.lc_y     = 5'(r[2].y);
      bus.lc_wdata = CW'(r[2].wd);
      bus.lc_lock  = lock_v;
      #2;
      check_cycle(do_rst);
   endtask

   task automatic set_rq(input int i, input bit rq, input bit w, input int x, input int y, input int wd);
      r[i] = '{req: rq, we: w, x: x, y: y, wd: wd};
   endtask

   task automatic idle_all();
      for (int i = 0; i < 3; i++) set_rq(i, 0, 0, 0, 0, 0);
   endtask

   // Response monitor, decoupled from stimulus.
   initial begin
      exp_t e;
      logic [2:0] rv;
      forever begin
         @(negedge clk);
         #1;
         rv = {bus.lc_rvalid, bus.ap_rvalid, bus.vid_rvalid};
         if (rv != 3'b000) begin
            if (expq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rvalid_unexpected cycle=%0d actual=%b expected=000", cyc, rv);
            end else begin
               e = expq.pop_front();
               chk("rvalid_who", {29'd0, rv}, 1 << e.who);
               chk("rdata", {29'd0, bus.rdata}, e.data);
            end
         end else if (expq.size() > 0 && expq[0].cyc < cyc) begin
            e = expq.pop_front();
            checks++;
            failures++;
            $display("FAIL rvalid_missing cycle=%0d actual=000 expected=%b", cyc, 3'(1 << e.who));
         end
      end
   end

   initial begin
      int v;
      bus.vid_req = 0; bus.ap_req = 0; bus.lc_req = 0;
      bus.ap_we = 0; bus.lc_we = 0; bus.lc_lock = 0;
      bus.vid_x = 0; bus.ap_x = 0; bus.lc_x = 0;
      bus.vid_y = 0; bus.ap_y = 0; bus.lc_y = 0;
      bus.ap_wdata = 0; bus.lc_wdata = 0;
      for (int i = 0; i < 256; i++) begin
         v = int'($urandom_range(0, 7));
         mem[i] <= CW'(v);
         board_m[i] = v;
      end
      mem[53] <= 3'd4;
      board_m[53] = 4;
      rr_m = 0; lock_m = 0; lock_v = 0;
      idle_all();
      repeat (3) step(1);

      // Single ap read of (3,5) = address 53
      set_rq(1, 1, 0, 3, 5, 0); step(0);
      idle_all(); step(0);
      $display("txn: ap read (3,5)");

      // Three-way contention, then ap/lc alternation from reset pointer
      step(1);
      set_rq(0, 1, 0, 1, 1, 0); set_rq(1, 1, 0, 2, 2, 0); set_rq(2, 1, 0, 3, 3, 0);
      repeat (4) step(0);
      r[0].req = 0;
      repeat (4) step(0);
      idle_all(); step(0);
      $display("txn: vid priority and ap/lc round-robin");

      // Out-of-range reads and write
      set_rq(1, 1, 0, 10, 0, 0); step(0);
      set_rq(1, 1, 0, 0, 20, 0); step(0);
      set_rq(1, 1, 1, 10, 0, 5); step(0);
      idle_all(); set_rq(2, 1, 0, 0, 1, 0); step(0);
      idle_all(); step(0);
      $display("txn: out-of-range accesses");

      // Lock held against ap, then released with ap waiting
      lock_v = 1; set_rq(2, 1, 0, 4, 4, 0); step(0);
      set_rq(1, 1, 0, 5, 5, 0);
      repeat (5) step(0);
      lock_v = 0; step(0);
      idle_all(); step(0);
      $display("txn: lc lock");

      // Write then read-after-write to (0,0)
      set_rq(2, 1, 1, 0, 0, 2); step(0);
      idle_all(); set_rq(1, 1, 0, 0, 0, 0); step(0);
      idle_all(); step(0);
      $display("txn: write then read (0,0)");

      // Reset while an lc read is in flight under lock
      lock_v = 1; set_rq(2, 1, 0, 6, 6, 0); step(0);
      step(1);
      set_rq(1, 1, 0, 7, 7, 0); step(0);
      idle_all(); lock_v = 0; step(0);
      $display("txn: reset during locked lc read");

      // Randomised traffic honouring hold-until-granted
      for (int n = 0; n < 2000; n++) begin
         bit do_rst;
         for (int i = 0; i < 3; i++) begin
            if (!r[i].req || last_win == i) begin
               r[i].req = ($urandom_range(0, 99) < ((i == 0) ? 25 : 60));
               r[i].we  = (i != 0) && ($urandom_range(0, 2) == 0);
               r[i].x   = int'($urandom_range(0, 11));
               r[i].y   = int'($urandom_range(0, 21));
               r[i].wd  = int'($urandom_range(0, 7));
            end
         end
         if ($urandom_range(0, 7) == 0) lock_v = ($urandom_range(0, 2) != 0);
         do_rst = ($urandom_range(0, 199) == 0);
         step(do_rst);
      end
      idle_all(); lock_v = 0;
      repeat (2) step(0);
      $display("txn: random traffic done");
      chk("queue_drained", expq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
